// File: rtl/seg_scan_decoder_pkg.sv
// seg_pkg: constants and types shared between the seven-segment cathode driver
// and the scan decoder.
//   SEG_0..SEG_9, SEG_BLANK : active-low cathode patterns, {a,b,c,d,e,f,g} = seg[6:0]
//   DIGIT_BLANK, DIGIT_BAD  : values reported for an all-off or an unrecognised pattern
//   scan_state_e            : scan-decoder FSM states
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] DIGIT_BAD   = 4'hE;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational cathode-pattern to digit-value decoder.
//   seg_i   : active-low cathodes {a,b,c,d,e,f,g}
//   value_o : 0-9 for a recognised digit, DIGIT_BLANK for all-off, DIGIT_BAD otherwise
//   blank_o : pattern was all segments off
//   bad_o   : pattern was neither a digit nor blank
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] value_o,
    output logic       blank_o,
    output logic       bad_o
);

    // Table lookup of the cathode pattern
    always_comb begin
        value_o = DIGIT_BAD;
        blank_o = 1'b0;
        bad_o   = 1'b0;
        case (seg_i)
            SEG_0:     value_o = 4'd0;
            SEG_1:     value_o = 4'd1;
            SEG_2:     value_o = 4'd2;
            SEG_3:     value_o = 4'd3;
            SEG_4:     value_o = 4'd4;
            SEG_5:     value_o = 4'd5;
            SEG_6:     value_o = 4'd6;
            SEG_7:     value_o = 4'd7;
            SEG_8:     value_o = 4'd8;
            SEG_9:     value_o = 4'd9;
            SEG_BLANK: begin
                value_o = DIGIT_BLANK;
                blank_o = 1'b1;
            end
            default: begin
                value_o = DIGIT_BAD;
                bad_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: monitors a multiplexed seven-segment anode/cathode bus and
// recovers the value shown on each digit, publishing complete coherent frames.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   an          : anode enables, active-low, bit i selects digit i
//   seg         : cathodes, active-low, {a,b,c,d,e,f,g}
//   digits      : decoded values, digit i in [4i+3:4i]
//   blank, bad  : per-digit all-off / unrecognised-pattern flags
//   frame_valid : one-cycle pulse when digits/blank/bad were updated
//   stale       : no digit accepted for TIMEOUT_CYCLES cycles
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   bad,
    output logic                    frame_valid,
    output logic                    stale
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0]         STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0]         STAB_ONE = SW'(1);
    localparam logic [TW-1:0]         TO_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ALL_ONES = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] ALL_ZERO = {NUM_DIGITS{1'b0}};

    // Position of the (single) low anode bit
    function automatic logic [IW-1:0] sel_index(input logic [NUM_DIGITS-1:0] sel_n);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel_n[k]) idx = IW'(k);
        end
        return idx;
    endfunction

    logic [NUM_DIGITS-1:0]   an_q, an_p_q;
    logic [6:0]              seg_q, seg_p_q;
    scan_state_e             state_q, state_d;
    logic [SW-1:0]           stab_q, stab_d;
    logic [TW-1:0]           to_q, to_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] shd_val_q, shd_val_d;
    logic [NUM_DIGITS-1:0]   shd_blank_q, shd_blank_d, shd_bad_q, shd_bad_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d, bad_q, bad_d;
    logic                    fv_q, fv_d, stale_q, stale_d;

    logic [NUM_DIGITS-1:0]   sel_n_s;
    logic                    legal_s, changed_s, accept_s;
    logic [SW-1:0]           stab_inc_s;
    logic [TW-1:0]           to_inc_s;
    logic [IW-1:0]           idx_s;
    logic [3:0]              dec_val_s;
    logic                    dec_blank_s, dec_bad_s;

    seg_pattern_decode u_decode (
        .seg_i   (seg_q),
        .value_o (dec_val_s),
        .blank_o (dec_blank_s),
        .bad_o   (dec_bad_s)
    );

    // Legal select means exactly one anode low (one-hot test on the inverted bus)
    assign sel_n_s    = ~an_q;
    assign legal_s    = (sel_n_s != ALL_ZERO) && ((sel_n_s & (sel_n_s - NUM_DIGITS'(1))) == ALL_ZERO);
    assign changed_s  = {an_q, seg_q} != {an_p_q, seg_p_q};
    assign stab_inc_s = (stab_q == STAB_MAX) ? stab_q : stab_q + STAB_ONE;
    assign to_inc_s   = (to_q == TO_MAX) ? to_q : to_q + TW'(1);
    assign idx_s      = sel_index(sel_n_s);

    // Input capture plus one cycle of history for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q    <= ALL_ONES;
            seg_q   <= SEG_BLANK;
            an_p_q  <= ALL_ONES;
            seg_p_q <= SEG_BLANK;
        end else begin
            an_q    <= an;
            seg_q   <= seg;
            an_p_q  <= an_q;
            seg_p_q <= seg_q;
        end
    end

    // FSM state and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            stab_q  <= {SW{1'b0}};
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
        end
    end

    // FSM next state: any change restarts the stability count
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        case (state_q)
            ST_WAIT: begin
                if (legal_s) begin
                    state_d = ST_SETTLE;
                    stab_d  = STAB_ONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SETTLE: begin
                if (!legal_s) begin
                    state_d = ST_WAIT;
                    stab_d  = {SW{1'b0}};
                end else if (changed_s) begin
                    stab_d  = STAB_ONE;
                end else begin
                    stab_d  = stab_inc_s;
                    state_d = (stab_inc_s == STAB_MAX) ? ST_HOLD : ST_SETTLE;
                end
            end
            ST_HOLD: begin
                if (changed_s && legal_s) begin
                    state_d = ST_SETTLE;
                    stab_d  = STAB_ONE;
                end else if (changed_s) begin
                    state_d = ST_WAIT;
                    stab_d  = {SW{1'b0}};
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_WAIT;
                stab_d  = {SW{1'b0}};
            end
        endcase
    end

    // FSM output: accept on the cycle the count reaches the threshold
    always_comb begin
        if (state_q == ST_SETTLE && legal_s && !changed_s && stab_inc_s == STAB_MAX) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Shadow slots, frame assembly and timeout; an accept overrides a timeout
    always_comb begin
        shd_val_d   = shd_val_q;
        shd_blank_d = shd_blank_q;
        shd_bad_d   = shd_bad_q;
        seen_d      = seen_q;
        digits_d    = digits_q;
        blank_d     = blank_q;
        bad_d       = bad_q;
        fv_d        = 1'b0;
        to_d        = to_inc_s;
        stale_d     = stale_q;
        if (accept_s) begin
            shd_val_d[{idx_s, 2'b00} +: 4] = dec_val_s;
            shd_blank_d[idx_s]             = dec_blank_s;
            shd_bad_d[idx_s]               = dec_bad_s;
            seen_d  = seen_q | sel_n_s;
            to_d    = {TW{1'b0}};
            stale_d = 1'b0;
            // Publish from the updated shadow so the slot written now is included
            if (seen_d == ALL_ONES) begin
                digits_d = shd_val_d;
                blank_d  = shd_blank_d;
                bad_d    = shd_bad_d;
                fv_d     = 1'b1;
                seen_d   = ALL_ZERO;
            end else begin
                fv_d = 1'b0;
            end
        end else if (to_inc_s == TO_MAX) begin
            stale_d = 1'b1;
            seen_d  = ALL_ZERO;
        end else begin
            stale_d = stale_q;
        end
    end

    // Frame, shadow and timeout registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_val_q   <= {(4*NUM_DIGITS){1'b0}};
            shd_blank_q <= ALL_ZERO;
            shd_bad_q   <= ALL_ZERO;
            seen_q      <= ALL_ZERO;
            digits_q    <= {(4*NUM_DIGITS){1'b0}};
            blank_q     <= ALL_ONES;
            bad_q       <= ALL_ZERO;
            fv_q        <= 1'b0;
            to_q        <= {TW{1'b0}};
            stale_q     <= 1'b0;
        end else begin
            shd_val_q   <= shd_val_d;
            shd_blank_q <= shd_blank_d;
            shd_bad_q   <= shd_bad_d;
            seen_q      <= seen_d;
            digits_q    <= digits_d;
            blank_q     <= blank_d;
            bad_q       <= bad_d;
            fv_q        <= fv_d;
            to_q        <= to_d;
            stale_q     <= stale_d;
        end
    end

    assign digits      = digits_q;
    assign blank       = blank_q;
    assign bad         = bad_q;
    assign frame_valid = fv_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus randomised scans, every
// cycle compared against a run-length reference model of the bus.
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 16;
    localparam int TO = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] digits;
    logic [3:0]  blank, bad;
    logic        frame_valid, stale;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .digits(digits),
        .blank(blank), .bad(bad), .frame_valid(frame_valid), .stale(stale)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int tcount   = 0;
    int fv_cnt   = 0;
    int last_fv_t = -1;
    int t_e1     = 0;

    logic [6:0] SEGTAB [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    // Reference model: a constant legal bus value held for SC sampled edges is accepted on the next edge
    int          m_run_len, m_to;
    bit          m_run_valid, m_pend, m_fv, m_stale;
    logic [3:0]  m_last_an, m_pend_an, m_seen, m_shb, m_shd, m_blank, m_bad;
    logic [6:0]  m_last_seg, m_pend_seg;
    logic [3:0]  m_shv [4];
    logic [15:0] m_digits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_decode(input logic [6:0] s, output logic [3:0] v, output logic b, output logic d);
        v = 4'hE; b = 1'b0; d = 1'b1;
        if (s == 7'h7F) begin v = 4'hF; b = 1'b1; d = 1'b0; end
        for (int k = 0; k < 10; k++)
            if (SEGTAB[k] == s) begin v = 4'(k); b = 1'b0; d = 1'b0; end
    endfunction

    function automatic bit m_legal(input logic [3:0] a);
        return $countones(~a) == 1;
    endfunction

    function automatic int m_index(input logic [3:0] a);
        for (int k = 0; k < ND; k++) if (!a[k]) return k;
        return 0;
    endfunction

    task automatic model_reset();
        m_run_len = 0; m_run_valid = 1'b0; m_pend = 1'b0; m_to = 0;
        m_fv = 1'b0; m_stale = 1'b0; m_seen = 4'h0; m_shb = 4'h0; m_shd = 4'h0;
        for (int k = 0; k < ND; k++) m_shv[k] = 4'h0;
        m_digits = 16'h0; m_blank = 4'hF; m_bad = 4'h0;
    endtask

    task automatic model_edge();
        logic [3:0] v;
        logic       b, d;
        int         i;
        m_fv = 1'b0;
        if (m_pend) begin
            i = m_index(m_pend_an);
            m_decode(m_pend_seg, v, b, d);
            m_shv[i] = v; m_shb[i] = b; m_shd[i] = d; m_seen[i] = 1'b1;
            if (m_seen == 4'hF) begin
                for (int k = 0; k < ND; k++) m_digits[4*k +: 4] = m_shv[k];
                m_blank = m_shb; m_bad = m_shd; m_fv = 1'b1; m_seen = 4'h0;
            end
            m_to = 0; m_stale = 1'b0;
        end else begin
            if (m_to < TO) m_to++;
            if (m_to == TO) begin m_stale = 1'b1; m_seen = 4'h0; end
        end
        if (m_run_valid && an == m_last_an && seg == m_last_seg) m_run_len++;
        else begin m_run_len = 1; m_last_an = an; m_last_seg = seg; m_run_valid = 1'b1; end
        m_pend = m_legal(an) && (m_run_len == SC);
        m_pend_an = an; m_pend_seg = seg;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_edge();
        #1;
        tcount++;
        if (frame_valid === 1'b1) begin fv_cnt++; last_fv_t = tcount; end
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("stale", 32'(stale), 32'(m_stale));
        check("digits", 32'(digits), 32'(m_digits));
        check("blank", 32'(blank), 32'(m_blank));
        check("bad", 32'(bad), 32'(m_bad));
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an = a; seg = s;
        repeat (n) tick();
    endtask

    task automatic scan4(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3);
        drive(4'b1110, p0, 20);
        drive(4'b1101, p1, 20);
        drive(4'b1011, p2, 20);
        drive(4'b0111, p3, 20);
    endtask

    initial begin
        logic [3:0] ra;
        logic [6:0] rs;
        model_reset();
        repeat (3) tick();
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_blank", 32'(blank), 32'hF);
        check("reset_bad", 32'(bad), 32'h0);
        check("reset_fv", 32'(frame_valid), 32'h0);
        check("reset_stale", 32'(stale), 32'h0);
        rst_n = 1'b1;

        // Clean scan 5,0,2,3
        fv_cnt = 0;
        scan4(SEGTAB[5], SEGTAB[0], SEGTAB[2], SEGTAB[3]);
        drive(4'hF, 7'h7F, 5);
        check("clean_fv_count", 32'(fv_cnt), 32'd1);
        check("clean_digits", 32'(digits), 32'h3205);
        check("clean_blank", 32'(blank), 32'h0);
        check("clean_bad", 32'(bad), 32'h0);

        // Glitch on digit 0, which completes the frame
        fv_cnt = 0;
        drive(4'b1101, SEGTAB[1], 20);
        drive(4'b1011, SEGTAB[4], 20);
        drive(4'b0111, SEGTAB[6], 20);
        drive(4'b1110, SEGTAB[7], 10);
        drive(4'b1110, SEGTAB[8], 1);
        an = 4'b1110; seg = SEGTAB[9];
        tick();
        t_e1 = tcount;
        repeat (19) tick();
        check("glitch_fv_count", 32'(fv_cnt), 32'd1);
        check("glitch_latency", 32'(last_fv_t), 32'(t_e1 + SC));
        check("glitch_digits", 32'(digits), 32'h6419);

        // Blank and bad patterns
        scan4(SEGTAB[1], SEGTAB[4], 7'b1111111, 7'b1010101);
        drive(4'hF, 7'h7F, 5);
        check("bb_digits", 32'(digits), 32'hEF41);
        check("bb_blank", 32'(blank), 32'h4);
        check("bb_bad", 32'(bad), 32'h8);

        // Illegal selects, then a normal scan
        fv_cnt = 0;
        drive(4'b1100, SEGTAB[3], 50);
        check("illegal_state_1100", 32'(dut.state_q), 32'(seg_pkg::ST_WAIT));
        drive(4'b1111, SEGTAB[3], 50);
        check("illegal_state_1111", 32'(dut.state_q), 32'(seg_pkg::ST_WAIT));
        check("illegal_fv_count", 32'(fv_cnt), 32'd0);
        scan4(SEGTAB[6], SEGTAB[7], SEGTAB[8], SEGTAB[9]);
        check("resume_fv_count", 32'(fv_cnt), 32'd1);
        check("resume_digits", 32'(digits), 32'h9876);

        // Timeout after a partial frame
        fv_cnt = 0;
        drive(4'b1110, SEGTAB[1], 20);
        drive(4'b1101, SEGTAB[2], 20);
        drive(4'b1011, SEGTAB[3], 20);
        drive(4'hF, 7'h7F, TO + 10);
        check("timeout_stale", 32'(stale), 32'h1);
        check("timeout_digits_kept", 32'(digits), 32'h9876);
        check("timeout_fv_count", 32'(fv_cnt), 32'd0);
        scan4(SEGTAB[4], SEGTAB[5], SEGTAB[6], SEGTAB[7]);
        check("after_to_stale", 32'(stale), 32'h0);
        check("after_to_fv_count", 32'(fv_cnt), 32'd1);
        check("after_to_digits", 32'(digits), 32'h7654);

        // Randomised scans including short holds, illegal selects and odd patterns
        for (int r = 0; r < 200; r++) begin
            if ($urandom_range(0, 9) == 0) ra = 4'($urandom);
            else ra = ~(4'b0001 << (r % ND));
            case ($urandom_range(0, 7))
                6:       rs = 7'h7F;
                7:       rs = 7'($urandom);
                default: rs = SEGTAB[$urandom_range(0, 9)];
            endcase
            drive(ra, rs, $urandom_range(1, 26));
        end

        // Asynchronous reset in the middle of settling
        drive(4'b1110, SEGTAB[2], 8);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_digits", 32'(digits), 32'h0);
        check("async_blank", 32'(blank), 32'hF);
        check("async_bad", 32'(bad), 32'h0);
        check("async_fv", 32'(frame_valid), 32'h0);
        check("async_stale", 32'(stale), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        fv_cnt = 0;
        drive(4'b1110, SEGTAB[2], 20);
        drive(4'b1101, SEGTAB[3], 20);
        drive(4'b1011, SEGTAB[4], 20);
        check("post_reset_partial", 32'(fv_cnt), 32'd0);
        drive(4'b0111, SEGTAB[5], 20);
        check("post_reset_fv_count", 32'(fv_cnt), 32'd1);
        check("post_reset_digits", 32'(digits), 32'h5432);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
